// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack round controller.
// Build option: define SOFT17_HIT_EN to make the dealer hit on a soft 17.
package blackjack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P_DEAL = 3'd1,
    ST_D_DEAL = 3'd2,
    ST_P_TURN = 3'd3,
    ST_D_TURN = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_PLAYER = 2'b01,
    RES_DEALER = 2'b10,
    RES_PUSH   = 2'b11
  } result_t;

  localparam logic [5:0] DEALER_STAND = 6'd17;
  localparam logic [5:0] BLACKJACK    = 6'd21;
  localparam logic [5:0] SOFT_LIMIT   = 6'd11;
  localparam logic [3:0] RANK_MAX     = 4'd13;
  localparam logic [3:0] FACE_CAP     = 4'd10;

  // An ace counts 11 only while that keeps the hand at or below 21.
  function automatic logic [5:0] eff_total(input logic [5:0] hard, input logic ace);
    return (ace && (hard <= SOFT_LIMIT)) ? hard + 6'd10 : hard;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/card_value.sv
// Decodes a 6-bit card code ({suit, rank}) into validity, ace flag and point value.
module card_value
  import blackjack_pkg::*;
(
  input  logic [5:0] i_code,
  output logic       o_valid,
  output logic       o_is_ace,
  output logic [3:0] o_value
);

  logic [3:0] w_rank;
  logic       w_unused_suit;

  assign w_rank        = i_code[3:0];
  assign w_unused_suit = ^i_code[5:4];

  assign o_valid  = (w_rank != 4'd0) && (w_rank <= RANK_MAX);
  assign o_is_ace = (w_rank == 4'd1);
  assign o_value  = (w_rank > FACE_CAP) ? FACE_CAP : w_rank;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// One-round blackjack controller: edge-detected card strobes, hand totals, outcome.
// Build option: SOFT17_HIT_EN makes the dealer keep drawing on a soft 17.
module blackjack_round_ctrl
  import blackjack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        more,
  input  logic        stand,
  input  logic        dcard,
  input  logic [5:0]  switch,
  input  logic [5:0]  button,
  output logic [5:0]  player_total,
  output logic [5:0]  dealer_total,
  output logic [2:0]  state_o,
  output logic [1:0]  result,
  output logic        bad_card,
  output logic [15:0] disp_digits
);

  logic    r_more_q, r_stand_q, r_dcard_q;
  state_t  r_state;
  logic [5:0] r_p_hard, r_d_hard;
  logic    r_p_ace, r_d_ace;
  result_t r_result;
  logic    r_bad;

  logic       w_more_stb, w_stand_stb, w_dcard_stb;
  logic       w_p_valid, w_p_is_ace, w_d_valid, w_d_is_ace;
  logic [3:0] w_p_value, w_d_value;
  logic [5:0] w_p_sum, w_d_sum, w_p_eff, w_d_eff;
  logic       w_d_stands;

  assign w_more_stb  = more  & ~r_more_q;
  assign w_stand_stb = stand & ~r_stand_q;
  assign w_dcard_stb = dcard & ~r_dcard_q;

  card_value u_player_card (
    .i_code   (switch),
    .o_valid  (w_p_valid),
    .o_is_ace (w_p_is_ace),
    .o_value  (w_p_value)
  );

  card_value u_dealer_card (
    .i_code   (button),
    .o_valid  (w_d_valid),
    .o_is_ace (w_d_is_ace),
    .o_value  (w_d_value)
  );

  assign w_p_sum = r_p_hard + {2'b00, w_p_value};
  assign w_d_sum = r_d_hard + {2'b00, w_d_value};
  assign w_p_eff = eff_total(r_p_hard, r_p_ace);
  assign w_d_eff = eff_total(r_d_hard, r_d_ace);

`ifdef SOFT17_HIT_EN
  // A soft 17 is an ace still being counted as 11.
  assign w_d_stands = (w_d_eff > DEALER_STAND) ||
                      ((w_d_eff == DEALER_STAND) && !(r_d_ace && (r_d_hard <= SOFT_LIMIT)));
`else
  assign w_d_stands = (w_d_eff >= DEALER_STAND);
`endif

  always_ff @(posedge clk) begin
    // Edge registers track the inputs even in reset so held levels never strobe.
    r_more_q  <= more;
    r_stand_q <= stand;
    r_dcard_q <= dcard;
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_p_hard <= 6'd0;
      r_d_hard <= 6'd0;
      r_p_ace  <= 1'b0;
      r_d_ace  <= 1'b0;
      r_result <= RES_NONE;
      r_bad    <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      case (r_state)
        ST_IDLE, ST_P_DEAL: begin
          if (w_more_stb) begin
            if (w_p_valid) begin
              r_p_hard <= w_p_sum;
              r_p_ace  <= r_p_ace | w_p_is_ace;
              r_state  <= (r_state == ST_IDLE) ? ST_P_DEAL : ST_D_DEAL;
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        ST_D_DEAL: begin
          if (w_dcard_stb) begin
            if (w_d_valid) begin
              r_d_hard <= w_d_sum;
              r_d_ace  <= r_d_ace | w_d_is_ace;
              r_state  <= ST_P_TURN;
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        ST_P_TURN: begin
          // Reaching 21 ends the player's turn; stand beats a same-cycle hit.
          if (w_p_eff == BLACKJACK || w_stand_stb) begin
            r_state <= ST_D_TURN;
          end else if (w_more_stb) begin
            if (w_p_valid) begin
              r_p_hard <= w_p_sum;
              r_p_ace  <= r_p_ace | w_p_is_ace;
              if (w_p_sum > BLACKJACK) begin
                r_state  <= ST_RESULT;
                r_result <= RES_DEALER;
              end
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        ST_D_TURN: begin
          if (w_d_stands) begin
            r_state <= ST_RESULT;
            if (w_p_eff > w_d_eff)      r_result <= RES_PLAYER;
            else if (w_p_eff < w_d_eff) r_result <= RES_DEALER;
            else                        r_result <= RES_PUSH;
          end else if (w_dcard_stb) begin
            if (w_d_valid) begin
              r_d_hard <= w_d_sum;
              r_d_ace  <= r_d_ace | w_d_is_ace;
              if (w_d_sum > BLACKJACK) begin
                r_state  <= ST_RESULT;
                r_result <= RES_PLAYER;
              end
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        ST_RESULT: begin
          if (w_stand_stb) begin
            r_state  <= ST_IDLE;
            r_p_hard <= 6'd0;
            r_d_hard <= 6'd0;
            r_p_ace  <= 1'b0;
            r_d_ace  <= 1'b0;
            r_result <= RES_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign player_total = w_p_eff;
  assign dealer_total = w_d_eff;
  assign state_o      = r_state;
  assign result       = r_result;
  assign bad_card     = r_bad;
  assign disp_digits  = {to_bcd(w_p_eff), to_bcd(w_d_eff)};

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Randomized bench for blackjack_round_ctrl against a card-list reference model.
// Honours SOFT17_HIT_EN in the model when the design is built with it.
module tb_blackjack_round_ctrl;
  import blackjack_pkg::*;

  logic        clk = 1'b0;
  logic        reset, more, stand, dcard;
  logic [5:0]  switch, button;
  logic [5:0]  player_total, dealer_total;
  logic [2:0]  state_o;
  logic [1:0]  result;
  logic        bad_card;
  logic [15:0] disp_digits;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the cards actually held, the round phase and the outcome.
  int     pc[$];
  int     dc[$];
  state_t ph;
  int     res_exp;

  localparam int K_MORE = 0, K_STAND = 1, K_DCARD = 2, K_BOTH = 3;

  blackjack_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .more         (more),
    .stand        (stand),
    .dcard        (dcard),
    .switch       (switch),
    .button       (button),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .state_o      (state_o),
    .result       (result),
    .bad_card     (bad_card),
    .disp_digits  (disp_digits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int hand_hard(input bit dealer);
    int s = 0;
    if (dealer) foreach (dc[i]) s += (dc[i] > 10) ? 10 : dc[i];
    else        foreach (pc[i]) s += (pc[i] > 10) ? 10 : pc[i];
    return s;
  endfunction

  function automatic bit hand_ace(input bit dealer);
    bit a = 0;
    if (dealer) foreach (dc[i]) a |= (dc[i] == 1);
    else        foreach (pc[i]) a |= (pc[i] == 1);
    return a;
  endfunction

  function automatic int hand_eff(input bit dealer);
    int h = hand_hard(dealer);
    return (hand_ace(dealer) && h + 10 <= 21) ? h + 10 : h;
  endfunction

  function automatic bit dealer_done();
    int e = hand_eff(1'b1);
`ifdef SOFT17_HIT_EN
    if (e == 17 && hand_ace(1'b1) && hand_hard(1'b1) == 7) return 1'b0;
`endif
    return e >= 17;
  endfunction

  function automatic int exp_disp();
    int p = hand_eff(1'b0);
    int d = hand_eff(1'b1);
    return ((p / 10) << 12) | ((p % 10) << 8) | ((d / 10) << 4) | (d % 10);
  endfunction

  function automatic void model_clear();
    pc.delete();
    dc.delete();
    ph = ST_IDLE;
    res_exp = 0;
  endfunction

  // Transitions that need no strobe: player on 21, dealer finished drawing.
  function automatic void model_settle();
    if (ph == ST_P_TURN && hand_eff(1'b0) == 21) ph = ST_D_TURN;
    if (ph == ST_D_TURN && dealer_done()) begin
      ph = ST_RESULT;
      if (hand_eff(1'b0) > hand_eff(1'b1))      res_exp = 1;
      else if (hand_eff(1'b0) < hand_eff(1'b1)) res_exp = 2;
      else                                      res_exp = 3;
    end
  endfunction

  function automatic bit model_apply(input int kind, input int rank);
    bit m  = (kind == K_MORE) || (kind == K_BOTH);
    bit s  = (kind == K_STAND) || (kind == K_BOTH);
    bit d  = (kind == K_DCARD);
    bit ok = (rank >= 1) && (rank <= 13);
    bit bad = 1'b0;
    case (ph)
      ST_IDLE, ST_P_DEAL:
        if (m) begin
          if (!ok) bad = 1'b1;
          else begin
            pc.push_back(rank);
            ph = (ph == ST_IDLE) ? ST_P_DEAL : ST_D_DEAL;
          end
        end
      ST_D_DEAL:
        if (d) begin
          if (!ok) bad = 1'b1;
          else begin
            dc.push_back(rank);
            ph = ST_P_TURN;
          end
        end
      ST_P_TURN:
        if (s) ph = ST_D_TURN;
        else if (m) begin
          if (!ok) bad = 1'b1;
          else begin
            pc.push_back(rank);
            if (hand_hard(1'b0) > 21) begin
              ph = ST_RESULT;
              res_exp = 2;
            end
          end
        end
      ST_D_TURN:
        if (d) begin
          if (!ok) bad = 1'b1;
          else begin
            dc.push_back(rank);
            if (hand_hard(1'b1) > 21) begin
              ph = ST_RESULT;
              res_exp = 1;
            end
          end
        end
      ST_RESULT:
        if (s) model_clear();
      default: ;
    endcase
    return bad;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(ph));
    chk({tag, "_ptot"}, 32'(player_total), hand_eff(1'b0));
    chk({tag, "_dtot"}, 32'(dealer_total), hand_eff(1'b1));
    chk({tag, "_res"}, 32'(result), res_exp);
    chk({tag, "_disp"}, 32'(disp_digits), exp_disp());
  endtask

  task automatic run_event(input int kind, input logic [5:0] code);
    bit exp_bad;
    @(negedge clk);
    switch = (kind == K_DCARD) ? 6'($urandom) : code;
    button = (kind == K_DCARD) ? code : 6'($urandom);
    more   = (kind == K_MORE) || (kind == K_BOTH);
    stand  = (kind == K_STAND) || (kind == K_BOTH);
    dcard  = (kind == K_DCARD);
    exp_bad = model_apply(kind, int'(code[3:0]));
    @(posedge clk); #1;
    chk("bad_pulse", 32'(bad_card), 32'(exp_bad));
    chk("edge_state", 32'(state_o), 32'(ph));
    chk("edge_ptot", 32'(player_total), hand_eff(1'b0));
    chk("edge_dtot", 32'(dealer_total), hand_eff(1'b1));
    @(negedge clk);
    more = 1'b0; stand = 1'b0; dcard = 1'b0;
    @(posedge clk); #1;
    chk("bad_clear", 32'(bad_card), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    model_settle();
    check_all("settle");
    $display("evt kind=%0d rank=%0d state=%0d p=%0d d=%0d res=%0d",
             kind, code[3:0], state_o, player_total, dealer_total, result);
  endtask

  task automatic do_reset(input bit hold_more);
    @(negedge clk);
    reset = 1'b0; more = hold_more; stand = 1'b0; dcard = 1'b0;
    switch = 6'd5; button = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    check_all("rst");
    chk("rst_bad", 32'(bad_card), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("rel");
    @(negedge clk);
    more = 1'b0;
    @(posedge clk); #1;
    chk("rel_idle", 32'(state_o), 32'(ST_IDLE));
  endtask

  initial begin
    reset = 1'b0; more = 1'b0; stand = 1'b0; dcard = 1'b0;
    switch = 6'd0; button = 6'd0;
    model_clear();

    // more held high through reset release must not deal a card
    do_reset(1'b1);
    chk("r031_ptot", 32'(player_total), 32'd0);

    // ace + king, dealer 10 then 7
    run_event(K_MORE, 6'h11);
    run_event(K_MORE, 6'h2D);
    run_event(K_DCARD, 6'h0A);
    chk("r032_dturn", 32'(state_o), 32'(ST_D_TURN));
    run_event(K_DCARD, 6'h37);
    chk("r032_res", 32'(result), 32'b01);
    chk("r032_disp", 32'(disp_digits), 32'h2117);

    // player busts on a hit, dealer untouched
    do_reset(1'b0);
    run_event(K_MORE, 6'd10);
    run_event(K_MORE, 6'd10);
    run_event(K_DCARD, 6'd5);
    run_event(K_MORE, 6'd5);
    chk("r033_res", 32'(result), 32'b10);
    chk("r033_dtot", 32'(dealer_total), 32'd5);

    // invalid rank in P_TURN
    do_reset(1'b0);
    run_event(K_MORE, 6'd10);
    run_event(K_MORE, 6'd5);
    run_event(K_DCARD, 6'd4);
    run_event(K_MORE, 6'd14);
    chk("r034_ptot", 32'(player_total), 32'd15);
    chk("r034_state", 32'(state_o), 32'(ST_P_TURN));

    // soft 17 for the dealer
    do_reset(1'b0);
    run_event(K_MORE, 6'd10);
    run_event(K_MORE, 6'd9);
    run_event(K_DCARD, 6'd1);
    run_event(K_STAND, 6'd0);
    run_event(K_DCARD, 6'd6);
`ifdef SOFT17_HIT_EN
    chk("r035_state", 32'(state_o), 32'(ST_D_TURN));
`else
    chk("r035_res", 32'(result), 32'b01);
`endif

    // same-cycle hit and stand
    do_reset(1'b0);
    run_event(K_MORE, 6'd10);
    run_event(K_MORE, 6'd5);
    run_event(K_DCARD, 6'd9);
    run_event(K_BOTH, 6'd3);
    chk("r036_state", 32'(state_o), 32'(ST_D_TURN));
    chk("r036_ptot", 32'(player_total), 32'd15);

    // random play
    do_reset(1'b0);
    for (int n = 0; n < 300; n++) begin
      int pick;
      int kind;
      logic [3:0] rank;
      pick = int'($urandom_range(0, 99));
      kind = (pick < 40) ? K_MORE : (pick < 60) ? K_STAND : (pick < 90) ? K_DCARD : K_BOTH;
      if ($urandom_range(0, 9) == 0) begin
        pick = int'($urandom_range(0, 2));
        rank = (pick == 0) ? 4'd0 : (pick == 1) ? 4'd14 : 4'd15;
      end else begin
        rank = 4'($urandom_range(1, 13));
      end
      run_event(kind, {2'($urandom), rank});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
